// File: rtl/matmul_feeder_pkg.sv
`default_nettype none
// ============================================================================
// matmul_pkg : shared constants, lane encodings and FSM states for the
//              2x2 multiplier and its operand feeder.   Rev 1.0
// ============================================================================
package matmul_pkg;

  // Two skew stages plus one MAC stage between the feeder and the accumulators
  localparam int DRAIN_CYCLES = 3;

  localparam logic [1:0] LANE_A0 = 2'd0;
  localparam logic [1:0] LANE_A1 = 2'd1;
  localparam logic [1:0] LANE_B0 = 2'd2;
  localparam logic [1:0] LANE_B1 = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/feeder_lane_buf.sv
`default_nettype none
// ============================================================================
// feeder_lane_buf : K x DW operand register file, one write port, one
//                   combinational read port, synchronous clear.   Rev 1.0
// ============================================================================
module feeder_lane_buf #(
  parameter int DW = 32,
  parameter int K  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [IW-1:0] i_wr_idx,
  input  logic [DW-1:0] i_wr_data,
  input  logic [IW-1:0] i_rd_idx,
  output logic [DW-1:0] o_rd_data
);

  // Sized to the full index range so any read index is legal; entries >= K
  // are never written and stay at their cleared value.
  localparam int          ENTRIES = 2 ** IW;
  localparam logic [IW:0] c_DEPTH = (IW + 1)'(K);

  logic [DW-1:0] r_mem [ENTRIES];
  logic          w_wr_ok;

  assign w_wr_ok = i_we && ({1'b0, i_wr_idx} < c_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/matmul_feeder.sv
`default_nettype none
// ============================================================================
// matmul_feeder : buffers 2xK A and Kx2 B operands and streams aligned
//                 k-slices into the 2x2 systolic multiplier.   Rev 1.0
// ============================================================================
module matmul_feeder
  import matmul_pkg::*;
#(
  parameter int DW = 32,
  parameter int K  = 4,
  parameter int IW = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_en,
  input  logic [1:0]    ld_lane,
  input  logic [IW-1:0] ld_idx,
  input  logic [DW-1:0] ld_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          acc_clr,
  output logic [DW-1:0] out_a0,
  output logic [DW-1:0] out_a1,
  output logic [DW-1:0] out_b0,
  output logic [DW-1:0] out_b1
);

  localparam int CNT_MAX = (K > DRAIN_CYCLES) ? K : DRAIN_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] c_LAST_BEAT  = CW'(K - 1);
  // The DONE cycle is itself the last drain cycle, so DRAIN lasts one less.
  localparam logic [CW-1:0] c_LAST_DRAIN = CW'(DRAIN_CYCLES - 2);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_busy;
  logic          r_done;
  logic          r_acc_clr;
  logic [DW-1:0] r_out_a0;
  logic [DW-1:0] r_out_a1;
  logic [DW-1:0] r_out_b0;
  logic [DW-1:0] r_out_b1;
  logic [DW-1:0] w_rd [4];
  logic [IW-1:0] w_rd_idx;
  logic          w_feed_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      S_CLEAR: begin
        w_state_nxt = S_FEED;
        w_cnt_nxt   = '0;
      end
      S_FEED: begin
        if (r_cnt == c_LAST_BEAT) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_cnt == c_LAST_DRAIN) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Buffers are read at the upcoming beat index so lane registers line up
  // with the state register.
  assign w_rd_idx   = IW'(w_cnt_nxt);
  assign w_feed_nxt = (w_state_nxt == S_FEED);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic w_we;
      assign w_we = ld_en && !r_busy && (ld_lane == 2'(gi));

      feeder_lane_buf #(
        .DW (DW),
        .K  (K),
        .IW (IW)
      ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_wr_idx  (ld_idx),
        .i_wr_data (ld_data),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_acc_clr <= 1'b0;
      r_out_a0  <= '0;
      r_out_a1  <= '0;
      r_out_b0  <= '0;
      r_out_b1  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_DONE);
      r_acc_clr <= (w_state_nxt == S_CLEAR);
      r_out_a0  <= w_feed_nxt ? w_rd[LANE_A0] : '0;
      r_out_a1  <= w_feed_nxt ? w_rd[LANE_A1] : '0;
      r_out_b0  <= w_feed_nxt ? w_rd[LANE_B0] : '0;
      r_out_b1  <= w_feed_nxt ? w_rd[LANE_B1] : '0;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign acc_clr = r_acc_clr;
  assign out_a0  = r_out_a0;
  assign out_a1  = r_out_a1;
  assign out_b0  = r_out_b0;
  assign out_b1  = r_out_b1;

endmodule
`default_nettype wire

// File: doc/matmul_feeder.md
# matmul_feeder

Operand sequencer directly upstream of the 2x2 systolic matrix multiplier. It buffers a 2xK A operand and a Kx2 B operand loaded over a simple write port. On `start` it pulses an accumulator clear, then streams one k-slice per cycle onto the multiplier's four input lanes. It signals `done` in the first cycle the multiplier's four accumulators hold the final products. Skew between lanes is handled inside the multiplier, so this block presents all four lanes aligned.

## Interface
- `DW`, 32: operand width; must match the multiplier input width.
- `K`, 4: inner dimension, number of stream beats; K >= 1.
- `IW`, $clog2(K) (min 1): width of the load index.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ld_en`  in  1  write strobe for the operand buffer.
- `ld_lane`  in  2  buffer select: 0 = a0 (A row 0), 1 = a1 (A row 1), 2 = b0 (B column 0), 3 = b1 (B column 1).
- `ld_idx`  in  IW  element index k within the lane.
- `ld_data`  in  DW  element value.
- `start`  in  1  begin a multiply; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted through the `done` cycle.
- `done`  out  1  one-cycle pulse; multiplier outputs are final in this cycle.
- `acc_clr`  out  1  one-cycle pulse; the top level ORs it into the multiplier reset.
- `out_a0`, `out_a1`, `out_b0`, `out_b1`  out  DW each  lane data to the multiplier `in_a0`/`in_a1`/`in_b0`/`in_b1`.

## Operation
- Buffer: four lanes of K x DW.
  - A write with `ld_en=1` while not busy stores `ld_data` at [`ld_lane`][`ld_idx`].
  - Writes are ignored while `busy=1`.
  - Writes with `ld_idx >= K` are ignored.
  - Contents persist across runs, so a second `start` reuses the loaded operands.
- FSM states and transitions:
  - IDLE -> CLEAR when `start=1`.
  - CLEAR (1 cycle) -> FEED.
  - FEED (K cycles) -> DRAIN.
  - DRAIN (DRAIN_CYCLES = 3) -> DONE.
  - DONE (1 cycle) -> IDLE.
- All outputs are registered.
  - `acc_clr` is 1 during CLEAR.
  - Lane outputs carry buffer[lane][k] on beat k and 0 at all other times.
  - `done` is 1 only during DONE.
- `start` is ignored outside IDLE. `start` held high re-launches from IDLE the cycle after DONE.
- Result relation, checked by the bench and not computed here:
  - o00 = Σ a0[k]·b0[k]
  - o01 = Σ a0[k]·b1[k]
  - o10 = Σ a1[k]·b0[k]
  - o11 = Σ a1[k]·b1[k]
  - Products are 2·DW wide, and the sum wraps at 2·DW.
- `rst` (including mid-run):
  - Next cycle: IDLE, all outputs 0, buffer cleared to 0.
  - The multiplier is reset by the same `rst`.

## Timing
- Cycle 0 is the cycle in which `start=1` is sampled in IDLE.
- Cycle 1: `acc_clr=1`, `busy=1`.
- Cycles 2..K+1: beat k = cycle−2 on all four lanes.
- Cycles K+2..K+4: lanes 0; DRAIN covers 2 skew stages plus 1 MAC stage.
- Cycle K+4: `done=1`, `busy=1`; o00..o11 final and stable until the next `acc_clr`.
- Cycle K+5: `busy=0`; the earliest next start is sampled here.
- Total occupancy is K+4 cycles per run.
- K=1: one beat in cycle 2, `done` in cycle 5.
- Reset values: `busy`, `done`, `acc_clr` and all lane outputs are 0.

## Structure
- Package `matmul_pkg` holds:
  - `DRAIN_CYCLES` = 3.
  - The `ld_lane` encodings (`LANE_A0`..`LANE_B1`).
  - The FSM state enum (`S_IDLE`, `S_CLEAR`, `S_FEED`, `S_DRAIN`, `S_DONE`).
- The multiplier top imports the same package.
- One sub-module, `feeder_lane_buf`: a K x DW register file with one write port, one combinational read port and synchronous clear. It is instantiated four times.
- Beat and drain counting use a single shared counter in the FSM.

## Test plan
- K=2, load a0={1,2}, a1={3,4}, b0={5,7}, b1={6,8}, then pulse `start`:
  - lanes show (1,3,5,6) in cycle 2 and (2,4,7,8) in cycle 3;
  - `done` in cycle 6;
  - multiplier o00=19, o01=22, o10=43, o11=50.
- Back-to-back runs: `start` held high, second run with the same operands:
  - `acc_clr` re-pulses;
  - results are again 19/22/43/50, not doubled;
  - `done` is 7 cycles apart.
- Load attempt during FEED, writing 99 to a0[0]: ignored; a rerun still gives o00=19.
- `rst` in cycle 3 of a run:
  - next cycle `busy=0` and all lanes 0;
  - buffer reads all 0;
  - a subsequent `start` gives all results 0.
- K=1, a0={0xFFFFFFFF}, b0={0xFFFFFFFF}, others 0:
  - `done` in cycle 5;
  - o00 = 0xFFFFFFFE00000001, others 0.
- `start` pulsed while busy and `ld_idx` = K: both ignored; timing and results unchanged.
